// File: rtl/cryp_lane_engine_if.sv
// Block-level bus for cryp_lane_engine: key load, upstream and downstream valid/ready handshakes.
// master drives blocks and keys in; slave is the engine.
interface cryp_lane_engine_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 16
);
  logic                    key_load;
  logic [LANES*LANE_W-1:0] key_in;
  logic                    key_valid;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_mode;
  logic [LANES*LANE_W-1:0] in_data;
  logic                    in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*LANE_W-1:0] out_data;
  logic                    out_tag;

  modport master (
    output key_load, key_in, in_valid, in_mode, in_data, in_tag, out_ready,
    input  key_valid, in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  key_load, key_in, in_valid, in_mode, in_data, in_tag, out_ready,
    output key_valid, in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/cryp_lane_engine.sv
// Two-stage LANES x LANE_W lane cipher (per-block decrypt/encrypt) with loadable key and popcount rotates.
// Optional macro CRYP_CHAIN_BLOCK_EN seeds lane 0 from the previous block's ciphertext top lane.

module cryp_lane #(
  parameter int LANE_W = 16,
  parameter int RW     = 4
) (
  input  logic [LANE_W-1:0] x_i,
  input  logic [LANE_W-1:0] k_i,
  input  logic [LANE_W-1:0] ch_i,
  input  logic [RW-1:0]     r_i,
  input  logic              enc_i,
  output logic [LANE_W-1:0] y_o
);
  logic [2*LANE_W-1:0] rr, rl;

  // Doubled operand makes a variable shift act as a rotate, including r = 0.
  always_comb begin
    rr  = {x_i, x_i} >> r_i;
    rl  = {x_i ^ ch_i, x_i ^ ch_i} << r_i;
    y_o = enc_i ? (rl[2*LANE_W-1:LANE_W] ^ k_i) : (rr[LANE_W-1:0] ^ ch_i);
  end
endmodule

module cryp_lane_engine #(
  parameter int                LANE_W = 16,
  parameter int                LANES  = 4,
  parameter logic [LANE_W-1:0] IV     = 16'h1234
) (
  input logic               clk,
  input logic               reset,
  cryp_lane_engine_if.slave bus
);
  localparam int RW = $clog2(LANE_W);

  typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;
  typedef struct packed {
    lanes_t                   x;
    lanes_t                   raw;
    lanes_t                   key;
    logic [LANES-1:0][RW-1:0] cnt;
    logic                     enc;
    logic                     tag;
  } s1_t;

  lanes_t                   key_q, key_in_l, in_l, out_data_q, out_d;
  logic [LANES-1:0][RW-1:0] cnt_q, cnt_d;
  logic                     key_valid_q, out_tag_q;
  logic [2:1]               vld_pipe_q;
  s1_t                      s1_q, s1_d;
  logic                     s2_adv, s1_adv, in_fire;
  logic [LANE_W-1:0]        ch0;

  // RW-bit accumulator wraps at LANE_W, so a full lane rotates by 0.
  function automatic logic [RW-1:0] lane_rot(input logic [LANE_W-1:0] v);
    logic [RW-1:0] c;
    c = '0;
    for (int b = 0; b < LANE_W; b++) c = c + RW'(v[b]);
    return c;
  endfunction

  assign key_in_l     = bus.key_in;
  assign in_l         = bus.in_data;
  assign s2_adv       = !vld_pipe_q[2] || bus.out_ready;
  assign s1_adv       = s2_adv;
  assign bus.in_ready = key_valid_q && !bus.key_load && (!vld_pipe_q[1] || s1_adv);
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_comb begin
    s1_d  = '0;
    cnt_d = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt_d[i]  = lane_rot(key_in_l[i]);
      s1_d.x[i] = bus.in_mode ? in_l[i] : (in_l[i] ^ key_q[i]);
    end
    s1_d.raw = in_l;
    s1_d.key = key_q;
    s1_d.cnt = cnt_q;
    s1_d.enc = bus.in_mode;
    s1_d.tag = bus.in_tag;
  end

  // Encrypt chains on the previous lane's result, so lanes ripple inside S2.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] ch, y;
    if (g == 0) begin : g_head
      assign ch = ch0;
    end else begin : g_tail
      assign ch = s1_q.enc ? g_lane[g-1].y : s1_q.raw[g-1];
    end
    cryp_lane #(.LANE_W(LANE_W), .RW(RW)) u_lane (
      .x_i  (s1_q.x[g]),
      .k_i  (s1_q.key[g]),
      .ch_i (ch),
      .r_i  (s1_q.cnt[g]),
      .enc_i(s1_q.enc),
      .y_o  (y)
    );
    assign out_d[g] = y;
  end

`ifdef CRYP_CHAIN_BLOCK_EN
  logic [LANE_W-1:0] chain_q;
  assign ch0 = chain_q;
  always_ff @(posedge clk) begin
    if (reset || bus.key_load) chain_q <= IV;
    else if (s2_adv && vld_pipe_q[1])
      chain_q <= s1_q.enc ? out_d[LANES-1] : s1_q.raw[LANES-1];
  end
`else
  logic unused_raw_top;
  assign ch0            = IV;
  assign unused_raw_top = ^s1_q.raw[LANES-1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q       <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      vld_pipe_q  <= '0;
      s1_q        <= '0;
      out_data_q  <= '0;
      out_tag_q   <= 1'b0;
    end else begin
      if (bus.key_load) begin
        key_q       <= key_in_l;
        cnt_q       <= cnt_d;
        key_valid_q <= 1'b1;
      end
      if (in_fire) s1_q <= s1_d;
      if (in_fire || s1_adv) vld_pipe_q[1] <= in_fire;
      if (s2_adv) begin
        vld_pipe_q[2] <= vld_pipe_q[1];
        if (vld_pipe_q[1]) begin
          out_data_q <= out_d;
          out_tag_q  <= s1_q.tag;
        end
      end
    end
  end

  assign bus.key_valid = key_valid_q;
  assign bus.out_valid = vld_pipe_q[2];
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_cryp_lane_engine.sv
// Scoreboard bench for cryp_lane_engine (LANE_W=16, LANES=4, IV=16'h1234); build with
// CRYP_CHAIN_BLOCK_EN to also cover block chaining.
module tb_cryp_lane_engine;
  localparam logic [15:0] IVP = 16'h1234;

  typedef struct {
    logic [63:0] data;
    logic        tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [63:0] m_key = '0;
  logic [15:0] m_chain = IVP;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cryp_lane_engine_if #(.LANES(4), .LANE_W(16)) bus ();
  cryp_lane_engine #(.LANE_W(16), .LANES(4), .IV(IVP)) dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [15:0] rotr(input logic [15:0] v, input int r);
    logic [15:0] t;
    t = v;
    for (int i = 0; i < r; i++) t = {t[0], t[15:1]};
    return t;
  endfunction

  function automatic logic [15:0] rotl(input logic [15:0] v, input int r);
    logic [15:0] t;
    t = v;
    for (int i = 0; i < r; i++) t = {t[14:0], t[15]};
    return t;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] key, input logic [63:0] d,
                                        input logic enc, input logic [15:0] ch0);
    logic [63:0] o;
    logic [15:0] ch, k, x;
    int r;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      k = key[i*16 +: 16];
      x = d[i*16 +: 16];
      r = $countones(k) % 16;
      if (i == 0) ch = ch0;
      else if (enc) ch = o[(i-1)*16 +: 16];
      else ch = d[(i-1)*16 +: 16];
      if (enc) o[i*16 +: 16] = rotl(x ^ ch, r) ^ k;
      else o[i*16 +: 16] = rotr(x ^ k, r) ^ ch;
    end
    return o;
  endfunction

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: out_data=%h arrived with nothing expected", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e.data || bus.out_tag !== e.tag) begin
            n_fail++;
            $display("FAIL sb_data: out_data=%h tag=%b, required %h tag=%b",
                     bus.out_data, bus.out_tag, e.data, e.tag);
          end
        end
      end
    end
  endtask

  task automatic load_key(input logic [63:0] k);
    bus.key_load = 1'b1;
    bus.key_in   = k;
    @(posedge clk); #1;
    bus.key_load = 1'b0;
    m_key   = k;
    m_chain = IVP;
  endtask

  // Presents one block until accepted, then records its expected result.
  task automatic send(input logic [63:0] d, input logic enc, input logic t,
                      input logic fixed, input logic [63:0] fx);
    exp_t e;
    logic [63:0] mo;
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = enc;
    bus.in_tag   = t;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end else begin
      mo = model(m_key, d, enc, m_chain);
      e.data = fixed ? fx : mo;
      e.tag  = t;
      exp_q.push_back(e);
`ifdef CRYP_CHAIN_BLOCK_EN
      m_chain = enc ? mo[63:48] : d[63:48];
`endif
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d blocks outstanding, required 0", nm, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (bus.key_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.out_data !== 64'h0 || bus.out_tag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: kv=%b ov=%b ir=%b od=%h ot=%b, required all 0",
               bus.key_valid, bus.out_valid, bus.in_ready, bus.out_data, bus.out_tag);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL no_key_ready: in_ready=%b, required 0", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_vectors();
    load_key(64'h0);
    n_chk++;
    if (bus.key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL key_valid: key_valid=%b, required 1", bus.key_valid);
    end
    send(64'h0, 1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_1234);
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: out_valid=%b one edge after accept, required 0", bus.out_valid);
    end
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: out_valid=%b two edges after accept, required 1", bus.out_valid);
    end
    drain("vec0");
    @(posedge clk); #1;
    load_key(64'h0000_0000_0000_0001);
    send(64'h0000_0000_0000_0003, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0003_1235);
    load_key(64'h0000_0000_0000_0001);
    send(64'h0000_0000_0003_1235, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_0003);
    drain("vec");
  endtask

  task automatic test_roundtrip();
    logic [63:0] x, y;
    logic t;
    int c0;
    for (int p = 0; p < 500; p++) begin
      if (p % 50 == 0) load_key({$urandom, $urandom});
      x  = {$urandom, $urandom};
      t  = 1'($urandom_range(0, 1));
      y  = model(m_key, x, 1'b1, m_chain);
      c0 = cyc;
      send(x, 1'b1, t, 1'b0, 64'h0);
`ifdef CRYP_CHAIN_BLOCK_EN
      send(y, 1'b0, ~t, 1'b0, 64'h0);
`else
      send(y, 1'b0, ~t, 1'b1, x);
`endif
      n_chk++;
      if (cyc - c0 != 2) begin
        n_fail++;
        $display("FAIL rt_throughput: pair took %0d cycles, required 2", cyc - c0);
      end
    end
    drain("rt");
  endtask

  task automatic test_stall();
    logic [63:0] hold;
    logic        bad;
    load_key(64'h0F0F_00FF_1357_ACE1);
    fork
      begin
        for (int i = 0; i < 8; i++) send({$urandom, $urandom}, 1'(i), 1'(i >> 1), 1'b0, 64'h0);
      end
      begin
        repeat (2) @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        hold = bus.out_data;
        n_chk++;
        if (bus.out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_valid: out_valid=%b, required 1", bus.out_valid);
        end
        bad = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (bus.out_data !== hold) bad = 1'b1;
        end
        n_chk++;
        if (bad) begin
          n_fail++;
          $display("FAIL stall_hold: out_data=%h, required %h", bus.out_data, hold);
        end
        n_chk++;
        if (bus.in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_ready: in_ready=%b with both stages full, required 0", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("stall");
  endtask

  task automatic test_key_switch();
    logic [63:0] b3;
    load_key(64'h00FF_0F0F_0003_0001);
    send({$urandom, $urandom}, 1'b0, 1'b1, 1'b0, 64'h0);
    send({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 64'h0);
    b3 = {$urandom, $urandom};
    bus.key_load = 1'b1;
    bus.key_in   = 64'h1357_9BDF_2468_ACE0;
    bus.in_valid = 1'b1;
    bus.in_data  = b3;
    bus.in_mode  = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_cycle_ready: in_ready=%b during key_load, required 0", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.key_load = 1'b0;
    m_key   = 64'h1357_9BDF_2468_ACE0;
    m_chain = IVP;
    send(b3, 1'b0, 1'b1, 1'b0, 64'h0);
    drain("keysw");
    // Reset with two blocks in flight: nothing may come out afterwards.
    @(posedge clk); #1;
    send({$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 64'h0);
    send({$urandom, $urandom}, 1'b1, 1'b1, 1'b0, 64'h0);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.key_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: ov=%b kv=%b ir=%b, required 0 0 0",
               bus.out_valid, bus.key_valid, bus.in_ready);
    end
    repeat (5) @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_out: out_valid=%b after reset, required 0", bus.out_valid);
    end
    @(posedge clk); #1;
  endtask

`ifdef CRYP_CHAIN_BLOCK_EN
  task automatic test_chain();
    load_key(64'h0);
    send(64'h0005_0000_0000_0000, 1'b0, 1'b0, 1'b1, 64'h0005_0000_0000_1234);
    send(64'h0, 1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_0005);
    drain("chain");
  endtask
`endif

  initial begin
    bus.key_load  = 1'b0;
    bus.key_in    = '0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_data   = '0;
    bus.in_tag    = 1'b0;
    bus.out_ready = 1'b1;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_vectors();
    test_roundtrip();
    test_stall();
    test_key_switch();
`ifdef CRYP_CHAIN_BLOCK_EN
    test_chain();
`endif
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cryp_lane_engine.md
Name: cryp_lane_engine

Overview:
- Parametrised successor of the team's fixed 4x16-bit decrypt pipeline.
- Handles LANES lanes of LANE_W bits each.
- Runs in decrypt or encrypt mode, chosen per block.
- Uses valid/ready handshakes on both sides, with full backpressure, and holds a loadable key register with precomputed per-lane popcounts.
- Sits between the link framer (ciphertext side) and the payload buffer (cleartext side).

Parameters:
LANE_W, 16, bits per lane; power of two, at least 4
LANES, 4, lane count; at least 2
IV, 16'h1234, LANE_W-bit chaining seed for lane 0

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
key_load  in  1  pulse: capture key_in
key_in  in  LANES*LANE_W  new key; lane i = bits [i*LANE_W +: LANE_W]
key_valid  out  1  a key has been loaded since reset
in_valid  in  1  input block valid
in_ready  out  1  input block accepted when in_valid && in_ready
in_mode  in  1  0 = decrypt, 1 = encrypt; sampled with the block
in_data  in  LANES*LANE_W  input block
in_tag  in  1  sideband flag; passed through untouched
out_valid  out  1  output block valid
out_ready  in  1  downstream accept
out_data  out  LANES*LANE_W  result block
out_tag  out  1  tag of the output block

Behaviour:
- Notation:
  - k_i = key lane i.
  - r_i = popcount(k_i) mod LANE_W, so a count of LANE_W rotates by 0.
  - ror/rol = rotate right/left within LANE_W bits.
- Key register:
  - On key_load, key_r <= key_in and cnt_r[i] <= r_i in the same cycle.
  - key_valid <= 1 on that edge.
  - in_ready = key_valid && !key_load && (!s1_valid || s1_adv).
  - Blocks already in the pipeline carry their own key/count copy in the S1 register, so they finish with the old key.
- Decrypt, with d = in lanes:
  - out_i = ror(d_i ^ k_i, r_i) ^ ch_i.
  - ch_0 = IV; ch_i = d_{i-1}.
- Encrypt, with c = in lanes:
  - out_i = rol(c_i ^ ch_i, r_i) ^ k_i.
  - ch_0 = IV; ch_i = out_{i-1}. This is a ripple across lanes inside S2.
  - Encrypt is the exact inverse of decrypt for the same key.
- Pipeline, two register stages:
  - S1 captures: lanes (d^k for decrypt, raw c for encrypt), previous-lane chain sources, cnt_r, key_r, mode, tag, s1_valid.
  - S2 computes and registers out_data, out_tag, out_valid.
  - s2_adv = !out_valid || out_ready.
  - s1_adv = s2_adv (S1 moves into S2 whenever S2 can accept).
  - Latency: accept at edge N gives out_valid at edge N+2 when out_ready stays high. Throughput is 1 block/cycle.
- Stall:
  - While out_valid && !out_ready, out_data and out_tag hold stable.
  - When both S1 and S2 are full, in_ready = 0.
  - No block is dropped or duplicated.
- Reset (synchronous): key_valid = 0, key_r = 0, cnt_r = 0, s1_valid = 0, out_valid = 0, out_data = 0, out_tag = 0.
  - Reset mid-stream discards all in-flight blocks.
  - in_ready is low on the cycle after reset until a key is loaded.
- key_load and in_valid in the same cycle: the block is not accepted (in_ready = 0) and must be re-presented by the source.
- Back-to-back key_load: the last one wins.
- Mixed modes may follow each other block by block with no bubble.

Optional Feature:
- Macro: CRYP_CHAIN_BLOCK_EN.
- When defined:
  - ch_0 = chain_r instead of IV.
  - chain_r is updated on each S2 load to the block's ciphertext top lane (d_{LANES-1} when decrypting, out_{LANES-1} when encrypting).
  - chain_r is reset to IV by reset and by key_load.
- When undefined: ch_0 = IV for every block, and chain_r does not exist.

Test Plan (LANE_W = 16, LANES = 4, IV = 16'h1234):
- Load key 0, decrypt in_data = 64'h0 with tag 1 -> out_data = 64'h0000_0000_0000_1234, out_tag = 1, two cycles after accept.
- Load key 64'h0000_0000_0000_0001, decrypt 64'h0000_0000_0000_0003 -> out_data = 64'h0000_0000_0003_1235.
- Same key, encrypt 64'h0000_0000_0003_1235 -> out_data = 64'h0000_0000_0000_0003. Also run a random round-trip of 1000 blocks with random keys and back-to-back alternating modes, checking decrypt(encrypt(x)) == x.
- Stream 8 blocks with out_ready low for cycles 3-7:
  - in_ready drops after two blocks are held.
  - out_data stays stable while stalled.
  - All 8 blocks emerge in order with no loss.
- key_load while two blocks are in flight -> those two use the old key; in_ready = 0 in the load cycle; the next block uses the new key. Also pulse reset mid-stream -> out_valid = 0 next cycle, key_valid = 0, no stale output after reset.
- With CRYP_CHAIN_BLOCK_EN, decrypt two blocks, key 0:
  - Block 1 = 64'h0005_0000_0000_0000 -> out_data = 64'h0005_0000_0000_1234.
  - Block 2 = 64'h0 -> out_data = 64'h0000_0000_0000_0005.
